// File: rtl/forwarding_unit_mp.sv
// forwarding_unit_mp
//   Multi-port, multi-stage operand forwarding unit for the RISC-V pipeline.
//   Each source port resolves its operand combinationally. The youngest
//   matching in-flight producer stage wins. If no stage matches, a short
//   history of retired writes is searched, newest entry first. If nothing
//   matches, the register-file read data is used.
//   A matching producer whose data is not ready yet raises a hazard. If the
//   consumer uses that port, stall is asserted. A watchdog sets a sticky
//   flag after STALL_MAX consecutive stall cycles.
//
// Optional build macro:
//   FWD_PERF_CNT_EN  enables the saturating forward/stall performance
//                    counters. When it is undefined, both counter outputs
//                    read 0.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   stage_valid     per-stage "holds a register write"
//   stage_ready     per-stage "write data available"
//   stage_addr      per-stage destination register  (NUM_STAGES*AW)
//   stage_data      per-stage write data            (NUM_STAGES*XLEN)
//   wb_valid/addr/data  retiring write, pushed into the history
//   src_used        per-port "operand actually consumed"
//   src_addr        per-port source register        (NUM_SRC*AW)
//   src_rf_data     per-port register-file data     (NUM_SRC*XLEN)
//   src_data        per-port resolved operand       (combinational)
//   src_fwd         per-port "forwarded from stage or history"
//   stall           hazard on a used port           (combinational)
//   stall_timeout   sticky watchdog flag
//   perf_fwd_cnt    cycles with any forwarded port
//   perf_stall_cnt  cycles with stall asserted
module forwarding_unit_mp #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 3,
  parameter int HIST_DEPTH = 2,
  parameter int STALL_MAX  = 16,
  parameter int CNT_W      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_STAGES-1:0]      stage_valid,
  input  logic [NUM_STAGES-1:0]      stage_ready,
  input  logic [NUM_STAGES*AW-1:0]   stage_addr,
  input  logic [NUM_STAGES*XLEN-1:0] stage_data,
  input  logic                       wb_valid,
  input  logic [AW-1:0]              wb_addr,
  input  logic [XLEN-1:0]            wb_data,
  input  logic [NUM_SRC-1:0]         src_used,
  input  logic [NUM_SRC*AW-1:0]      src_addr,
  input  logic [NUM_SRC*XLEN-1:0]    src_rf_data,
  output logic [NUM_SRC*XLEN-1:0]    src_data,
  output logic [NUM_SRC-1:0]         src_fwd,
  output logic                       stall,
  output logic                       stall_timeout,
  output logic [CNT_W-1:0]           perf_fwd_cnt,
  output logic [CNT_W-1:0]           perf_stall_cnt
);

  localparam int RUN_W = $clog2(STALL_MAX + 1);

  logic [HIST_DEPTH-1:0]           hist_valid;
  logic [HIST_DEPTH-1:0][AW-1:0]   hist_addr;
  logic [HIST_DEPTH-1:0][XLEN-1:0] hist_data;

  logic [NUM_SRC-1:0] hazard;
  logic [AW-1:0]      cur_addr;
  logic               matched;

  logic [RUN_W-1:0] stall_run;
  logic [RUN_W-1:0] stall_run_nxt;

  // Operand resolution. The first match in scan order wins. A younger stage
  // that is not ready still claims the port, so an older ready stage or a
  // history entry can never supply stale data in its place.
  always_comb begin
    src_data = '0;
    src_fwd  = '0;
    hazard   = '0;
    cur_addr = '0;
    matched  = 1'b0;
    for (int unsigned j = 0; j < NUM_SRC; j++) begin
      cur_addr = src_addr[j*AW +: AW];
      matched  = 1'b0;
      if (cur_addr == '0) begin
        src_data[j*XLEN +: XLEN] = '0;
      end else begin
        src_data[j*XLEN +: XLEN] = src_rf_data[j*XLEN +: XLEN];
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
          if (!matched && stage_valid[i] && (stage_addr[i*AW +: AW] == cur_addr)) begin
            matched = 1'b1;
            if (stage_ready[i]) begin
              src_data[j*XLEN +: XLEN] = stage_data[i*XLEN +: XLEN];
              src_fwd[j]               = 1'b1;
            end else begin
              hazard[j] = 1'b1;
            end
          end
        end
        for (int unsigned k = 0; k < HIST_DEPTH; k++) begin
          if (!matched && hist_valid[k] && (hist_addr[k] == cur_addr)) begin
            matched                  = 1'b1;
            src_data[j*XLEN +: XLEN] = hist_data[k];
            src_fwd[j]               = 1'b1;
          end
        end
      end
    end
  end

  assign stall = |(src_used & hazard);

  // Retired-write history. Entry 0 is the newest. Writes to x0 are never recorded.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_valid <= '0;
    end else if (wb_valid && (wb_addr != '0)) begin
      for (int unsigned k = 1; k < HIST_DEPTH; k++) begin
        hist_valid[k] <= hist_valid[k-1];
        hist_addr[k]  <= hist_addr[k-1];
        hist_data[k]  <= hist_data[k-1];
      end
      hist_valid[0] <= 1'b1;
      hist_addr[0]  <= wb_addr;
      hist_data[0]  <= wb_data;
    end
  end

  // Stall watchdog. The run counter saturates at STALL_MAX.
  always_comb begin
    stall_run_nxt = '0;
    if (stall) begin
      if (stall_run == RUN_W'(STALL_MAX)) stall_run_nxt = stall_run;
      else                                stall_run_nxt = stall_run + RUN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_run     <= '0;
      stall_timeout <= 1'b0;
    end else begin
      stall_run <= stall_run_nxt;
      if (stall_run_nxt == RUN_W'(STALL_MAX)) stall_timeout <= 1'b1;
    end
  end

`ifdef FWD_PERF_CNT_EN
  logic [CNT_W-1:0] fwd_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if ((|src_fwd) && (fwd_cnt_q != '1)) fwd_cnt_q   <= fwd_cnt_q + CNT_W'(1);
      if (stall && (stall_cnt_q != '1))    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign perf_fwd_cnt   = fwd_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_fwd_cnt   = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule
